// File: rtl/byte_serial_data_mem.sv
// Byte-serial data memory for RV32I loads/stores.
// Storage is a single-port byte array, so every access moves one byte per
// cycle and holds the pipeline with stall until the access is finished.
module byte_serial_data_mem #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]           r_state;
  logic [1:0]           r_cnt;
  logic [1:0]           r_last;      // index of the final byte (n-1)
  logic [2:0]           r_f3;
  logic [ADDR_BITS-1:0] r_base;
  logic [31:0]          r_wdata;
  logic [31:0]          r_shift;
  logic [31:0]          r_rdata;
  logic                 r_done;
  logic                 r_err;
  logic                 r_is_store;

  logic [7:0] r_mem [0:(1<<ADDR_BITS)-1];

  logic                 w_req;
  logic                 w_illegal;
  logic                 w_misal;
  logic                 w_bad;
  logic [ADDR_BITS-1:0] w_baddr;
  logic [7:0]           w_rbyte;
  logic [7:0]           w_wbyte;
  logic [31:0]          w_shift_nxt;
  logic [31:0]          w_fmt;
  logic                 w_unused_addr;

  assign w_unused_addr = &{1'b0, addr[31:ADDR_BITS]};

  assign w_req     = MemRead | MemWrite;
  assign w_illegal = (funct3[1:0] == 2'b11) | (funct3[2] & (MemWrite | funct3[1]));
  assign w_misal   = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
  assign w_bad     = w_illegal | w_misal | (MemRead & MemWrite);

  // Byte address wraps naturally within the ADDR_BITS-wide sum.
  assign w_baddr = r_base + ADDR_BITS'(r_cnt);
  assign w_rbyte = r_mem[w_baddr];

  assign stall = (r_state == S_XFER) | ((r_state == S_IDLE) & w_req);
  assign rdata = r_rdata;
  assign done  = r_done;
  assign err   = r_err;

  // Select the store byte for the current lane
  always_comb begin
    w_wbyte = r_wdata[7:0];
    case (r_cnt)
      2'd0: w_wbyte = r_wdata[7:0];
      2'd1: w_wbyte = r_wdata[15:8];
      2'd2: w_wbyte = r_wdata[23:16];
      2'd3: w_wbyte = r_wdata[31:24];
      default: w_wbyte = r_wdata[7:0];
    endcase
  end

  // Merge this cycle's read byte so the final byte is available on DONE entry
  always_comb begin
    w_shift_nxt = r_shift;
    case (r_cnt)
      2'd0: w_shift_nxt[7:0]   = w_rbyte;
      2'd1: w_shift_nxt[15:8]  = w_rbyte;
      2'd2: w_shift_nxt[23:16] = w_rbyte;
      2'd3: w_shift_nxt[31:24] = w_rbyte;
      default: w_shift_nxt = r_shift;
    endcase
  end

  // Sign/zero-extend the assembled load data by access type
  always_comb begin
    w_fmt = w_shift_nxt;
    case (r_f3)
      3'b000: w_fmt = {{24{w_shift_nxt[7]}}, w_shift_nxt[7:0]};
      3'b001: w_fmt = {{16{w_shift_nxt[15]}}, w_shift_nxt[15:0]};
      3'b100: w_fmt = {24'd0, w_shift_nxt[7:0]};
      3'b101: w_fmt = {16'd0, w_shift_nxt[15:0]};
      default: w_fmt = w_shift_nxt;
    endcase
  end

  // Storage write port; contents are deliberately not cleared by reset
  always_ff @(posedge clk) begin
    if (!rst && (r_state == S_XFER) && r_is_store) begin
      r_mem[w_baddr] <= w_wbyte;
    end
  end

  // Access sequencing: latch request, move n bytes, one-cycle completion
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_last     <= '0;
      r_f3       <= '0;
      r_base     <= '0;
      r_wdata    <= '0;
      r_shift    <= '0;
      r_rdata    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_is_store <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_req) begin
            if (w_bad) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
              if (MemRead) r_rdata <= '0;
            end else begin
              r_state    <= S_XFER;
              r_cnt      <= '0;
              r_base     <= addr[ADDR_BITS-1:0];
              r_f3       <= funct3;
              r_wdata    <= wdata;
              r_shift    <= '0;
              r_is_store <= MemWrite;
              case (funct3[1:0])
                2'b00:   r_last <= 2'd0;
                2'b01:   r_last <= 2'd1;
                default: r_last <= 2'd3;
              endcase
            end
          end
        end
        S_XFER: begin
          if (!r_is_store) r_shift <= w_shift_nxt;
          if (r_cnt == r_last) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            if (!r_is_store) r_rdata <= w_fmt;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
